// File: rtl/key_if.sv
// Key pin / event bundle between the board keys and the mode control logic.
// The master drives the raw pins; the slave reports debounced levels and pulses.
interface key_if #(
    parameter int KEY_NUM = 4
);
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;
    logic [KEY_NUM-1:0] key_repeat;

    modport master (
        output key_in,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_repeat
    );

    modport slave (
        input  key_in,
        output key_state,
        output key_press,
        output key_release,
        output key_long,
        output key_repeat
    );
endinterface

// File: rtl/key_filter_ctrl.sv
// Per-key synchroniser, debouncer and press/release/long/repeat classifier.
// Every key runs its own FSM and counters; all events are registered 1-cycle pulses.
module key_filter_ctrl #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int KEY_NUM     = 4,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic sys_clk,
    input  logic rst_n,
    key_if.slave bus
);
    localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_MS;
    localparam int REP_CYC  = CLK_FREQ / 1000 * REPEAT_MS;

    localparam logic [31:0] DB_LAST   = 32'(DB_CYC - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CYC - 1);
    localparam logic [31:0] REP_LAST  = 32'(REP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        LONG_HELD,
        REL_DB
    } state_t;

    logic [KEY_NUM-1:0] meta;
    logic [KEY_NUM-1:0] sync;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            meta <= '1;
            sync <= '1;
        end else begin
            meta <= bus.key_in;
            sync <= meta;
        end
    end

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        state_t      state;
        state_t      state_nxt;
        logic [31:0] cnt;
        logic [31:0] cnt_nxt;
        logic [31:0] hold;
        logic [31:0] hold_nxt;
        logic [31:0] rep;
        logic [31:0] rep_nxt;
        logic        from_long;
        logic        from_long_nxt;
        logic        rep_hit;
        logic        level_q;
        logic        press_q;
        logic        release_q;
        logic        long_q;
        logic        repeat_q;
        logic        level_nxt;
        logic        press_nxt;
        logic        release_nxt;
        logic        long_nxt;
        logic        s;

        assign s = sync[k];

        always_ff @(posedge sys_clk) begin
            if (!rst_n) begin
                state     <= IDLE;
                cnt       <= '0;
                hold      <= '0;
                rep       <= '0;
                from_long <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                hold      <= hold_nxt;
                rep       <= rep_nxt;
                from_long <= from_long_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
                repeat_q  <= rep_hit;
            end
        end

        // Returning from a release glitch resumes the frozen counter in that cycle.
        always_comb begin
            state_nxt     = state;
            cnt_nxt       = cnt;
            hold_nxt      = hold;
            rep_nxt       = rep;
            from_long_nxt = from_long;
            rep_hit       = 1'b0;
            unique case (state)
                IDLE: begin
                    if (!s) begin
                        cnt_nxt   = '0;
                        hold_nxt  = '0;
                        state_nxt = (DB_CYC == 1) ? HELD : PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (s) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                        if (cnt + 32'd1 >= DB_LAST) begin
                            state_nxt = HELD;
                            hold_nxt  = '0;
                        end
                    end
                end
                HELD: begin
                    if (s) begin
                        from_long_nxt = 1'b0;
                        cnt_nxt       = '0;
                        state_nxt     = (DB_CYC == 1) ? IDLE : REL_DB;
                    end else if (hold >= LONG_LAST) begin
                        state_nxt = LONG_HELD;
                        rep_nxt   = '0;
                    end else begin
                        hold_nxt = hold + 32'd1;
                    end
                end
                LONG_HELD: begin
                    if (s) begin
                        from_long_nxt = 1'b1;
                        cnt_nxt       = '0;
                        state_nxt     = (DB_CYC == 1) ? IDLE : REL_DB;
                    end else if (rep >= REP_LAST) begin
                        rep_hit = 1'b1;
                        rep_nxt = '0;
                    end else begin
                        rep_nxt = rep + 32'd1;
                    end
                end
                REL_DB: begin
                    if (!s) begin
                        if (from_long) begin
                            state_nxt = LONG_HELD;
                            rep_nxt   = rep + 32'd1;
                        end else begin
                            state_nxt = HELD;
                            hold_nxt  = hold + 32'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                        if (cnt + 32'd1 >= DB_LAST) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_comb begin
            level_nxt   = (state_nxt == HELD) || (state_nxt == LONG_HELD)
                          || (state_nxt == REL_DB);
            press_nxt   = (state_nxt == HELD)
                          && ((state == IDLE) || (state == PRESS_DB));
            long_nxt    = (state_nxt == LONG_HELD) && (state == HELD);
            release_nxt = (state_nxt == IDLE) && level_q;
        end

        assign bus.key_state[k]   = level_q;
        assign bus.key_press[k]   = press_q;
        assign bus.key_release[k] = release_q;
        assign bus.key_long[k]    = long_q;
        assign bus.key_repeat[k]  = repeat_q;
    end

endmodule
